// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS            = 8;
    localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: pulses tick on the last clk of each UART bit while run is high.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic tick
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q;

    assign tick = run && (cnt_q == CntMax);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (!run || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Two-port round-robin UART transmit scheduler: arbitrates byte requests and
// serialises each granted byte as an 8N1 frame on tx.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       tx,
    output logic       busy,
    output logic       grant_id
);

    uart_state_e               state_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic [2:0]                bit_idx_q;
    logic                      last_grant_q;
    logic                      tick;
    logic                      sel;
    logic                      xfer;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .run    (state_q != StIdle),
        .tick   (tick)
    );

    // On a tie the port not granted last time wins; otherwise the only valid port.
    always_comb begin
        sel        = req1_valid && (!req0_valid || !last_grant_q);
        req0_ready = reset_n && (state_q == StIdle) && req0_valid && !sel;
        req1_ready = reset_n && (state_q == StIdle) && req1_valid && sel;
        xfer       = req0_ready || req1_ready;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            shift_q      <= '0;
            bit_idx_q    <= '0;
            last_grant_q <= 1'b1;
            grant_id     <= 1'b0;
            tx           <= 1'b1;
            busy         <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (xfer) begin
                        state_q      <= StStart;
                        shift_q      <= sel ? req1_data : req0_data;
                        bit_idx_q    <= '0;
                        grant_id     <= sel;
                        last_grant_q <= sel;
                        tx           <= 1'b0;
                        busy         <= 1'b1;
                    end
                end
                StStart: begin
                    if (tick) begin
                        state_q <= StData;
                        tx      <= shift_q[0];
                    end
                end
                StData: begin
                    if (tick) begin
                        if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
                            state_q <= StStop;
                            tx      <= 1'b1;
                        end else begin
                            // tx tracks the LSB of the shifted register
                            shift_q   <= shift_q >> 1;
                            tx        <= shift_q[1];
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end
                end
                StStop: begin
                    if (tick) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: two instances (CLKS_PER_BIT 4 and 2).
module tb_uart_tx_sched;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       a_r0v = 1'b0, a_r1v = 1'b0, b_r0v = 1'b0;
    logic [7:0] a_r0d = 8'h00, a_r1d = 8'h00, b_r0d = 8'h00;
    logic       a_r0rdy, a_r1rdy, b_r0rdy, b_r1rdy;
    logic [1:0] tx_v, busy_v, gid_v;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        logic [7:0] data;
        logic       gid;
        int         start;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_sched #(.CLKS_PER_BIT(4)) dut_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .req0_valid(a_r0v),
        .req0_data (a_r0d),
        .req0_ready(a_r0rdy),
        .req1_valid(a_r1v),
        .req1_data (a_r1d),
        .req1_ready(a_r1rdy),
        .tx        (tx_v[0]),
        .busy      (busy_v[0]),
        .grant_id  (gid_v[0])
    );

    uart_tx_sched #(.CLKS_PER_BIT(2)) dut_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .req0_valid(b_r0v),
        .req0_data (b_r0d),
        .req0_ready(b_r0rdy),
        .req1_valid(1'b0),
        .req1_data (8'h00),
        .req1_ready(b_r1rdy),
        .tx        (tx_v[1]),
        .busy      (busy_v[1]),
        .grant_id  (gid_v[1])
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic g, input int s);
        exp_t e;
        e.data  = d;
        e.gid   = g;
        e.start = s;
        exp_q.push_back(e);
    endtask

    // Captures one whole frame from instance d and checks it against the queue head.
    task automatic monitor(input int d, input int cpb);
        logic        prev = 1'b0;
        logic        aborted;
        logic        g;
        logic [39:0] smp;
        logic [9:0]  pat;
        logic [7:0]  dec;
        int          start, bad, mism;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (reset_n && busy_v[d] && !prev) begin
                start   = cyc;
                g       = gid_v[d];
                bad     = 0;
                aborted = 1'b0;
                smp     = '0;
                for (int i = 0; i < 10 * cpb; i++) begin
                    if (i > 0) @(negedge clk);
                    if (!reset_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    smp[i] = tx_v[d];
                    if (!busy_v[d]) bad++;
                end
                if (aborted) begin
                    prev = 1'b0;
                end else begin
                    @(negedge clk);
                    chk("frame busy length", bad, 0);
                    chk("idle after stop", int'({busy_v[d], tx_v[d]}), 1);
                    prev = busy_v[d];
                    chk("frame expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e    = exp_q.pop_front();
                        pat  = {1'b1, e.data, 1'b0};
                        mism = 0;
                        for (int i = 0; i < 10 * cpb; i++) begin
                            if (smp[i] != pat[i / cpb]) mism++;
                        end
                        for (int k = 0; k < 8; k++) dec[k] = smp[(k + 1) * cpb + cpb / 2];
                        chk("frame byte", int'(dec), int'(e.data));
                        chk("frame line samples", mism, 0);
                        chk("frame grant_id", int'(g), int'(e.gid));
                        chk("frame start cycle", start, e.start);
                    end
                end
            end else begin
                prev = busy_v[d];
            end
        end
    endtask

    task automatic wait_idle(input int max);
        for (int n = 0; n < max; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && busy_v == 2'b00) break;
        end
        chk("scoreboard drained", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, c, bad;
        fork
            monitor(0, 4);
            monitor(1, 2);
        join_none

        // Reset values, with a valid request held to show ready stays low in reset
        a_r0v = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset tx", int'(tx_v), 3);
        chk("reset busy", int'(busy_v), 0);
        chk("reset grant_id", int'(gid_v), 0);
        chk("reset req0_ready", int'(a_r0rdy), 0);
        chk("reset req1_ready", int'(a_r1rdy), 0);
        a_r0v = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // Single byte 0xA5 on port 0, ready for exactly one cycle
        @(negedge clk);
        a_r0v = 1'b1;
        a_r0d = 8'hA5;
        #1 chk("A5 req0_ready", int'(a_r0rdy), 1);
        t = cyc;
        push(8'hA5, 1'b0, t + 1);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            #1 if (a_r0rdy) bad++;
        end
        chk("A5 ready one cycle", bad, 0);
        a_r0v = 1'b0;
        wait_idle(60);

        // Both ports valid straight out of reset: strict alternation, 41-cycle spacing
        @(negedge clk);
        reset_n = 1'b0;
        a_r0v = 1'b1;
        a_r0d = 8'h11;
        a_r1v = 1'b1;
        a_r1d = 8'h22;
        @(negedge clk);
        reset_n = 1'b1;
        c = cyc;
        push(8'h11, 1'b0, c + 1);
        push(8'h22, 1'b1, c + 42);
        push(8'h11, 1'b0, c + 83);
        push(8'h22, 1'b1, c + 124);
        while (cyc < c + 126) @(negedge clk);
        a_r0v = 1'b0;
        a_r1v = 1'b0;
        wait_idle(60);

        // Port 1 arrives mid-frame and waits for IDLE
        @(negedge clk);
        a_r0v = 1'b1;
        a_r0d = 8'h5A;
        #1 chk("5A req0_ready", int'(a_r0rdy), 1);
        t = cyc;
        push(8'h5A, 1'b0, t + 1);
        @(negedge clk);
        a_r0v = 1'b0;
        repeat (9) @(negedge clk);
        a_r1v = 1'b1;
        a_r1d = 8'hC3;
        push(8'hC3, 1'b1, t + 42);
        bad = 0;
        while (cyc < t + 41) begin
            #1 if (a_r1rdy) bad++;
            @(negedge clk);
        end
        #1;
        chk("req1_ready low mid-frame", bad, 0);
        chk("req1_ready at idle", int'(a_r1rdy), 1);
        @(negedge clk);
        a_r1v = 1'b0;
        wait_idle(60);

        // Reset during frame cycle 15 of 0x3C
        @(negedge clk);
        a_r0v = 1'b1;
        a_r0d = 8'h3C;
        t = cyc;
        @(negedge clk);
        a_r0v = 1'b0;
        while (cyc < t + 15) @(negedge clk);
        chk("busy before reset", int'(busy_v[0]), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async reset tx", int'(tx_v[0]), 1);
        chk("async reset busy", int'(busy_v[0]), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx_v[0] != 1'b1 || busy_v[0] != 1'b0) bad++;
        end
        chk("idle after reset release", bad, 0);

        // CLKS_PER_BIT=2: 0xFF then 0x00 back-to-back, 1-cycle IDLE gap
        @(negedge clk);
        b_r0v = 1'b1;
        b_r0d = 8'hFF;
        #1 chk("FF req0_ready", int'(b_r0rdy), 1);
        t = cyc;
        push(8'hFF, 1'b0, t + 1);
        push(8'h00, 1'b0, t + 22);
        @(negedge clk);
        b_r0d = 8'h00;
        while (cyc < t + 22) @(negedge clk);
        b_r0v = 1'b0;
        wait_idle(40);

        // 1000 quiet cycles
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx_v != 2'b11 || busy_v != 2'b00) bad++;
            if (a_r0rdy || a_r1rdy || b_r0rdy || b_r1rdy) bad++;
        end
        chk("quiet line", bad, 0);

        wait_idle(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Two-requester UART transmit scheduler for the image-compression board link. It arbitrates byte requests from the compressed-data stream (port 0) and the status/debug path (port 1) with fair round-robin. It serialises each granted byte as an 8N1 frame on `tx` using its own baud counter. It replaces ad-hoc divided-clock UART timing with a single-clock-domain design.

## Interface
- `CLKS_PER_BIT`, default 434: clk cycles per UART bit (50 MHz / 115200). Legal range is 2 or more.
- `clk  in  1`: system clock, 50 MHz.
- `reset_n  in  1`: reset, asynchronous, active-low.
- `req0_valid  in  1`: port 0 (compressed data) has a byte.
- `req0_data  in  8`: port 0 byte. Held stable while valid.
- `req0_ready  out  1`: port 0 byte accepted this cycle.
- `req1_valid  in  1`: port 1 (status) has a byte.
- `req1_data  in  8`: port 1 byte.
- `req1_ready  out  1`: port 1 byte accepted this cycle.
- `tx  out  1`: serial line. Idle high.
- `busy  out  1`: a frame is in progress.
- `grant_id  out  1`: port whose byte is currently on the line.

## Operation
- Handshake: a transfer occurs on a rising edge where `reqN_valid && reqN_ready`.
  - A requester must not drop `valid` or change `data` before its transfer.
  - `reqN_ready` is combinational: it is high only in IDLE, and only for the selected port.
  - Ready never depends on any output of this block other than state.
- Arbitration happens in IDLE only.
  - If exactly one port is valid, that port is selected.
  - If both are valid, the port not granted last time is selected.
  - `last_grant` resets to 1, so port 0 wins the first tie.
  - `last_grant` updates on each transfer.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE → START on a transfer. The byte is latched into the shift register, `grant_id` is set, and the bit timer restarts.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then → DATA.
  - DATA: LSB first, 8 bits, each held CLKS_PER_BIT cycles. A 3-bit index is used, and after bit 7 the state goes → STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles, then → IDLE.
- Bit timer: counts 0..CLKS_PER_BIT-1.
  - The tick fires on the terminal count, and the counter then wraps to 0.
  - The counter is held at 0 in IDLE.
  - Counter width is $clog2(CLKS_PER_BIT).
- `busy` is high in START, DATA and STOP.
- `tx` is registered. It is 1 in IDLE and STOP, 0 in START, and equals the shift register LSB in DATA.
- A request arriving mid-frame waits. Valid requests are never lost or reordered within a port.
- Reset values: `tx`=1, `busy`=0, `grant_id`=0, both readies 0. State resets to IDLE, counter and index to 0, and `last_grant` to 1.
- Asserting reset mid-frame forces `tx` high asynchronously. The frame is abandoned, not resumed.
  - A requester whose byte was already accepted has lost it. Re-sending is the requester's responsibility.

## Timing
- Transfer edge T: `tx` falls and `busy` rises at T+1.
- Start bit occupies cycles T+1 .. T+CLKS_PER_BIT.
- Data bit k starts at T+1+(k+1)·CLKS_PER_BIT.
- Stop bit ends after T+10·CLKS_PER_BIT. IDLE is entered at T+10·CLKS_PER_BIT+1, and ready may assert in that same cycle.
- Back-to-back frame period is 10·CLKS_PER_BIT+1 cycles.
- `grant_id` is valid from T+1 and holds until the next transfer.

## Structure
- Shared package `uart_pkg` holds:
  - state enum (IDLE/START/DATA/STOP, 2-bit);
  - `UART_DATA_BITS`=8;
  - `UART_DEFAULT_CLKS_PER_BIT`=434.
- Sub-module `uart_bit_timer`:
  - parameter CLKS_PER_BIT;
  - inputs `clk`, `reset_n`, `run`;
  - output `tick`;
  - counter cleared whenever `run`=0.
- Arbiter and FSM live in the top level.

## Test plan
- CLKS_PER_BIT=4, single byte: port 0 sends 0xA5.
  - Expect `req0_ready` high 1 cycle.
  - `tx` sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1.
  - `busy` high for exactly 40 cycles.
- Both ports valid from reset, with port 0=0x11 and port 1=0x22 held continuously.
  - Frames must alternate 0x11, 0x22, 0x11, …
  - `grant_id` alternates 0,1,0.
  - Frame starts are 41 cycles apart.
- Port 1 asserts valid mid-frame of a port 0 byte.
  - `req1_ready` must stay low until IDLE.
  - The port 1 frame starts exactly 41 cycles after the port 0 transfer.
- Reset asserted at cycle 15 of a frame carrying 0x3C.
  - `tx`=1 and `busy`=0 immediately, without waiting for a clock edge.
  - After release, the line idles high until a new request arrives.
- Minimum CLKS_PER_BIT=2, port 0 sends 0xFF then 0x00 back-to-back.
  - Each frame is 20 cycles with a 1-cycle IDLE gap.
  - The stop bit and the next start bit are distinct.
- No requests for 1000 cycles: `tx`=1 and `busy`=0 throughout, and both readies stay 0.
